alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 ds_valid  input  1  decode stage presents an instruction this cycle.
REQ-004 ds_allowin  output  1  block accepts the presented instruction this cycle.
REQ-005 ds_inst  input  32  LA32R instruction word.
REQ-006 ds_pc  input  32  instruction PC.
REQ-007 ds_rj_value / ds_rkd_value  input  32 each  register-file operands.
REQ-008 es_flush  input  1  discard held and incoming instruction.
REQ-009 es_allowin  input  1  downstream execute stage consumes es outputs this cycle.
REQ-010 es_valid  output  1  registered outputs hold a live instruction.
REQ-011 alu_op  output  15  one-hot ALU control: bit0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 nor, 6 or, 7 xor, 8 sll, 9 srl, 10 sra, 11 lui, 12 mul.w, 13 mulh.w, 14 mulh.wu.
REQ-012 alu_src1 / alu_src2  output  32 each  ALU operands.
REQ-013 es_ine  output  1  instruction-not-exist flag for the held instruction.

Function
REQ-014 ds_allowin SHALL equal (!es_valid | es_allowin | es_flush), combinationally.
REQ-015 Transfer occurs when ds_valid & ds_allowin & !es_flush; on that edge es_valid<=1 and all es outputs load the decoded instruction (latency 1 cycle).
REQ-016 When es_valid & es_allowin and no transfer, es_valid<=0; data outputs hold their last value.
REQ-017 When es_valid & !es_allowin & !es_flush, all outputs SHALL remain bit-stable (no change while stalled).
REQ-018 es_flush SHALL have priority: next es_valid=0 regardless of ds_valid/es_allowin; a simultaneously presented instruction is dropped.
REQ-019 Decode on ds_inst[31:15]: 0x00020 add.w, 0x00022 sub.w, 0x00024 slt, 0x00025 sltu, 0x00028 nor, 0x00029 and, 0x0002A or, 0x0002B xor, 0x0002E sll.w, 0x0002F srl.w, 0x00030 sra.w, 0x00038 mul.w, 0x00039 mulh.w, 0x0003A mulh.wu, 0x00081 slli.w, 0x00089 srli.w, 0x00091 srai.w.
REQ-020 Decode on ds_inst[31:22]: 0x008 slti, 0x009 sltui, 0x00A addi.w, 0x00D andi, 0x00E ori, 0x00F xori; on ds_inst[31:25]: 0x0A lu12i.w (op lui), 0x0E pcaddu12i (op add).
REQ-021 alu_src1 = ds_pc for pcaddu12i, else ds_rj_value.
REQ-022 alu_src2: 3R ops ds_rkd_value; slti/sltui/addi.w sign-extended inst[21:10]; andi/ori/xori zero-extended inst[21:10]; shift-immediates {27'b0, inst[14:10]}; lu12i.w/pcaddu12i {inst[24:5], 12'b0}.
REQ-023 Exactly one alu_op bit SHALL be set for a recognised instruction.
REQ-024 Unrecognised encoding: alu_op=0, alu_src1/2=0, es_ine=1, es_valid still 1 (passed down for exception).

Reset
REQ-025 On reset: es_valid=0, alu_op=0, alu_src1=0, alu_src2=0, es_ine=0; ds_allowin=1 follows from REQ-014.
REQ-026 Reset asserted mid-stall SHALL discard the held instruction; first transfer possible on first edge after deassertion.

Configuration
REQ-027 Macro ALU_ISSUE_MUL_EN: defined, mul.w/mulh.w/mulh.wu decode to alu_op bits 12/13/14 with src2=ds_rkd_value.
REQ-028 Undefined, those three encodings SHALL be treated as unrecognised (REQ-024); alu_op[14:12] constant 0.

Structure
REQ-029 Shared package holds alu_op bit-index constants, ALU_OP_W=15, and all opcode field constants of REQ-019/020.
REQ-030 Combinational decoder sub-module alu_issue_dec (inst, pc, rj, rkd -> op, src1, src2, ine); alu_issue holds handshake and registers only.

Verification
REQ-031 add.w: ds_inst=0x00100C41, rj=5, rkd=7, es_allowin=1 -> next cycle es_valid=1, alu_op=0x0001, src1=5, src2=7.
REQ-032 addi.w si12=0xFFF (ds_inst=0x02BFFC41), rj=3 -> alu_op=0x0001, src2=0xFFFFFFFF; ori same imm -> alu_op=0x0040, src2=0x00000FFF.
REQ-033 pcaddu12i si20=0x12345, pc=0x1C000000 -> alu_op=0x0001, src1=0x1C000000, src2=0x12345000.
REQ-034 Stall: es_allowin=0 for 3 cycles with ds_valid=1 -> ds_allowin=0, outputs unchanged; es_allowin=1 -> next instruction loads one cycle later.
REQ-035 es_flush with ds_valid=1 and es_valid=1 -> next cycle es_valid=0; reset mid-stall -> es_valid=0 immediately.
REQ-036 ds_inst=0x001C0C41 (mul.w): with ALU_ISSUE_MUL_EN alu_op=0x1000, es_ine=0; without it alu_op=0, es_ine=1; ds_inst=0xFFFFFFFF -> es_ine=1 in both builds.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the LA32R ALU issue stage.
// Opcode field constants, ALU control bit indices and the decode bundle.
package alu_issue_pkg;

   localparam int ALU_OP_W = 15;

   localparam int ALU_ADD   = 0;
   localparam int ALU_SUB   = 1;
   localparam int ALU_SLT   = 2;
   localparam int ALU_SLTU  = 3;
   localparam int ALU_AND   = 4;
   localparam int ALU_NOR   = 5;
   localparam int ALU_OR    = 6;
   localparam int ALU_XOR   = 7;
   localparam int ALU_SLL   = 8;
   localparam int ALU_SRL   = 9;
   localparam int ALU_SRA   = 10;
   localparam int ALU_LUI   = 11;
   localparam int ALU_MUL   = 12;
   localparam int ALU_MULH  = 13;
   localparam int ALU_MULHU = 14;

   // inst[31:15]
   localparam logic [16:0] OP17_ADD_W   = 17'h00020;
   localparam logic [16:0] OP17_SUB_W   = 17'h00022;
   localparam logic [16:0] OP17_SLT     = 17'h00024;
   localparam logic [16:0] OP17_SLTU    = 17'h00025;
   localparam logic [16:0] OP17_NOR     = 17'h00028;
   localparam logic [16:0] OP17_AND     = 17'h00029;
   localparam logic [16:0] OP17_OR      = 17'h0002A;
   localparam logic [16:0] OP17_XOR     = 17'h0002B;
   localparam logic [16:0] OP17_SLL_W   = 17'h0002E;
   localparam logic [16:0] OP17_SRL_W   = 17'h0002F;
   localparam logic [16:0] OP17_SRA_W   = 17'h00030;
   localparam logic [16:0] OP17_MUL_W   = 17'h00038;
   localparam logic [16:0] OP17_MULH_W  = 17'h00039;
   localparam logic [16:0] OP17_MULH_WU = 17'h0003A;
   localparam logic [16:0] OP17_SLLI_W  = 17'h00081;
   localparam logic [16:0] OP17_SRLI_W  = 17'h00089;
   localparam logic [16:0] OP17_SRAI_W  = 17'h00091;

   // inst[31:22]
   localparam logic [9:0] OP10_SLTI   = 10'h008;
   localparam logic [9:0] OP10_SLTUI  = 10'h009;
   localparam logic [9:0] OP10_ADDI_W = 10'h00A;
   localparam logic [9:0] OP10_ANDI   = 10'h00D;
   localparam logic [9:0] OP10_ORI    = 10'h00E;
   localparam logic [9:0] OP10_XORI   = 10'h00F;

   // inst[31:25]
   localparam logic [6:0] OP7_LU12I_W   = 7'h0A;
   localparam logic [6:0] OP7_PCADDU12I = 7'h0E;

   typedef enum logic [2:0] {
      SRC2_RKD,
      SRC2_SI12,
      SRC2_UI12,
      SRC2_UI5,
      SRC2_SI20
   } src2_sel_e;

   typedef struct packed {
      logic [ALU_OP_W-1:0] op;
      logic [31:0]         src1;
      logic [31:0]         src2;
      logic                ine;
   } dec_t;

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational LA32R ALU instruction decoder.
// ALU_ISSUE_MUL_EN enables decode of mul.w / mulh.w / mulh.wu.
module alu_issue_dec
   import alu_issue_pkg::*;
(
   input  logic [31:0]         inst,
   input  logic [31:0]         pc,
   input  logic [31:0]         rj,
   input  logic [31:0]         rkd,
   output logic [ALU_OP_W-1:0] op,
   output logic [31:0]         src1,
   output logic [31:0]         src2,
   output logic                ine
);

   logic [16:0] f17;
   logic [9:0]  f10;
   logic [6:0]  f7;
   logic        hit;
   logic        use_pc;
   src2_sel_e   sel;
   logic [31:0] imm;
   logic        unused;

   assign f17    = inst[31:15];
   assign f10    = inst[31:22];
   assign f7     = inst[31:25];
   assign unused = ^inst[4:0];

   always_comb begin
      op     = '0;
      sel    = SRC2_RKD;
      use_pc = 1'b0;
      hit    = 1'b1;
      unique case (1'b1)
         (f17 == OP17_ADD_W):  op[ALU_ADD]  = 1'b1;
         (f17 == OP17_SUB_W):  op[ALU_SUB]  = 1'b1;
         (f17 == OP17_SLT):    op[ALU_SLT]  = 1'b1;
         (f17 == OP17_SLTU):   op[ALU_SLTU] = 1'b1;
         (f17 == OP17_NOR):    op[ALU_NOR]  = 1'b1;
         (f17 == OP17_AND):    op[ALU_AND]  = 1'b1;
         (f17 == OP17_OR):     op[ALU_OR]   = 1'b1;
         (f17 == OP17_XOR):    op[ALU_XOR]  = 1'b1;
         (f17 == OP17_SLL_W):  op[ALU_SLL]  = 1'b1;
         (f17 == OP17_SRL_W):  op[ALU_SRL]  = 1'b1;
         (f17 == OP17_SRA_W):  op[ALU_SRA]  = 1'b1;
`ifdef ALU_ISSUE_MUL_EN
         (f17 == OP17_MUL_W):   op[ALU_MUL]   = 1'b1;
         (f17 == OP17_MULH_W):  op[ALU_MULH]  = 1'b1;
         (f17 == OP17_MULH_WU): op[ALU_MULHU] = 1'b1;
`endif
         (f17 == OP17_SLLI_W): begin
            op[ALU_SLL] = 1'b1;
            sel         = SRC2_UI5;
         end
         (f17 == OP17_SRLI_W): begin
            op[ALU_SRL] = 1'b1;
            sel         = SRC2_UI5;
         end
         (f17 == OP17_SRAI_W): begin
            op[ALU_SRA] = 1'b1;
            sel         = SRC2_UI5;
         end
         (f10 == OP10_SLTI): begin
            op[ALU_SLT] = 1'b1;
            sel         = SRC2_SI12;
         end
         (f10 == OP10_SLTUI): begin
            op[ALU_SLTU] = 1'b1;
            sel          = SRC2_SI12;
         end
         (f10 == OP10_ADDI_W): begin
            op[ALU_ADD] = 1'b1;
            sel         = SRC2_SI12;
         end
         (f10 == OP10_ANDI): begin
            op[ALU_AND] = 1'b1;
            sel         = SRC2_UI12;
         end
         (f10 == OP10_ORI): begin
            op[ALU_OR] = 1'b1;
            sel        = SRC2_UI12;
         end
         (f10 == OP10_XORI): begin
            op[ALU_XOR] = 1'b1;
            sel         = SRC2_UI12;
         end
         (f7 == OP7_LU12I_W): begin
            op[ALU_LUI] = 1'b1;
            sel         = SRC2_SI20;
         end
         (f7 == OP7_PCADDU12I): begin
            op[ALU_ADD] = 1'b1;
            sel         = SRC2_SI20;
            use_pc      = 1'b1;
         end
         default: hit = 1'b0;
      endcase
   end

   always_comb begin
      imm = rkd;
      unique case (sel)
         SRC2_RKD:  imm = rkd;
         SRC2_SI12: imm = {{20{inst[21]}}, inst[21:10]};
         SRC2_UI12: imm = {20'b0, inst[21:10]};
         SRC2_UI5:  imm = {27'b0, inst[14:10]};
         SRC2_SI20: imm = {inst[24:5], 12'b0};
         default:   imm = rkd;
      endcase
   end

   // Unrecognised encodings carry zero operands so only ine is meaningful.
   assign src1 = !hit ? '0 : (use_pc ? pc : rj);
   assign src2 = hit ? imm : '0;
   assign ine  = !hit;

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decode-to-execute handshake and output registers.
// Build with ALU_ISSUE_MUL_EN to issue the multiply family.
module alu_issue
   import alu_issue_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                ds_valid,
   output logic                ds_allowin,
   input  logic [31:0]         ds_inst,
   input  logic [31:0]         ds_pc,
   input  logic [31:0]         ds_rj_value,
   input  logic [31:0]         ds_rkd_value,
   input  logic                es_flush,
   input  logic                es_allowin,
   output logic                es_valid,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic [31:0]         alu_src1,
   output logic [31:0]         alu_src2,
   output logic                es_ine
);

   dec_t dec;
   logic xfer;

   alu_issue_dec u_dec (
      .inst (ds_inst),
      .pc   (ds_pc),
      .rj   (ds_rj_value),
      .rkd  (ds_rkd_value),
      .op   (dec.op),
      .src1 (dec.src1),
      .src2 (dec.src2),
      .ine  (dec.ine)
   );

   assign ds_allowin = !es_valid | es_allowin | es_flush;
   assign xfer       = ds_valid & ds_allowin & !es_flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         es_valid <= 1'b0;
         alu_op   <= '0;
         alu_src1 <= '0;
         alu_src2 <= '0;
         es_ine   <= 1'b0;
      end else begin
         if (es_flush)
            es_valid <= 1'b0;
         else if (xfer)
            es_valid <= 1'b1;
         else if (es_allowin)
            es_valid <= 1'b0;
         // Data only moves on a transfer; a stall keeps it bit-stable.
         if (xfer) begin
            alu_op   <= dec.op;
            alu_src1 <= dec.src1;
            alu_src2 <= dec.src2;
            es_ine   <= dec.ine;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed cases plus randomized traffic
// against a table-driven reference model.
module tb_alu_issue;
   import alu_issue_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ds_valid = 1'b0;
   logic        ds_allowin;
   logic [31:0] ds_inst = '0;
   logic [31:0] ds_pc = '0;
   logic [31:0] ds_rj_value = '0;
   logic [31:0] ds_rkd_value = '0;
   logic        es_flush = 1'b0;
   logic        es_allowin = 1'b0;
   logic        es_valid;
   logic [14:0] alu_op;
   logic [31:0] alu_src1;
   logic [31:0] alu_src2;
   logic        es_ine;

   alu_issue dut (
      .clk          (clk),
      .reset        (reset),
      .ds_valid     (ds_valid),
      .ds_allowin   (ds_allowin),
      .ds_inst      (ds_inst),
      .ds_pc        (ds_pc),
      .ds_rj_value  (ds_rj_value),
      .ds_rkd_value (ds_rkd_value),
      .es_flush     (es_flush),
      .es_allowin   (es_allowin),
      .es_valid     (es_valid),
      .alu_op       (alu_op),
      .alu_src1     (alu_src1),
      .alu_src2     (alu_src2),
      .es_ine       (es_ine)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // kind: 0 rkd, 1 signed imm12, 2 unsigned imm12, 3 ui5, 4 imm20<<12, 5 imm20<<12 with pc
   typedef struct {
      int          lo;
      logic [31:0] code;
      int          bitn;
      int          kind;
   } ent_t;
   ent_t tbl[$];

   logic        m_valid;
   logic [14:0] m_op;
   logic [31:0] m_s1;
   logic [31:0] m_s2;
   logic        m_ine;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic add(input int lo, input int code, input int bitn,
                      input int kind);
      ent_t e;
      e.lo = lo;
      e.code = 32'(code);
      e.bitn = bitn;
      e.kind = kind;
      tbl.push_back(e);
   endtask

   task automatic build_tbl();
      add(15, 'h20, 0, 0);  add(15, 'h22, 1, 0);
      add(15, 'h24, 2, 0);  add(15, 'h25, 3, 0);
      add(15, 'h28, 5, 0);  add(15, 'h29, 4, 0);
      add(15, 'h2A, 6, 0);  add(15, 'h2B, 7, 0);
      add(15, 'h2E, 8, 0);  add(15, 'h2F, 9, 0);
      add(15, 'h30, 10, 0);
`ifdef ALU_ISSUE_MUL_EN
      add(15, 'h38, 12, 0); add(15, 'h39, 13, 0);
      add(15, 'h3A, 14, 0);
`endif
      add(15, 'h81, 8, 3);  add(15, 'h89, 9, 3);
      add(15, 'h91, 10, 3);
      add(22, 'h08, 2, 1);  add(22, 'h09, 3, 1);
      add(22, 'h0A, 0, 1);  add(22, 'h0D, 4, 2);
      add(22, 'h0E, 6, 2);  add(22, 'h0F, 7, 2);
      add(25, 'h0A, 11, 4); add(25, 'h0E, 0, 5);
   endtask

   function automatic void ref_dec(input logic [31:0] inst, pc, rj, rkd,
                                   output logic [14:0] op,
                                   output logic [31:0] s1, s2,
                                   output logic ine);
      int imm;
      op = '0;
      s1 = '0;
      s2 = '0;
      ine = 1'b1;
      foreach (tbl[i]) begin
         if ((inst >> tbl[i].lo) == tbl[i].code) begin
            op = 15'(1) << tbl[i].bitn;
            ine = 1'b0;
            s1 = (tbl[i].kind == 5) ? pc : rj;
            imm = int'((inst >> 10) & 32'hFFF);
            case (tbl[i].kind)
               0: s2 = rkd;
               1: s2 = 32'((imm >= 2048) ? imm - 4096 : imm);
               2: s2 = 32'(imm);
               3: s2 = (inst >> 10) & 32'd31;
               default: s2 = ((inst >> 5) & 32'hFFFFF) * 32'd4096;
            endcase
         end
      end
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_op = '0;
      m_s1 = '0;
      m_s2 = '0;
      m_ine = 1'b0;
   endtask

   task automatic set_in(input logic v, input logic [31:0] inst,
                         input logic [31:0] pc, input logic [31:0] rj,
                         input logic [31:0] rkd, input logic ea,
                         input logic fl);
      ds_valid = v;
      ds_inst = inst;
      ds_pc = pc;
      ds_rj_value = rj;
      ds_rkd_value = rkd;
      es_allowin = ea;
      es_flush = fl;
   endtask

   task automatic compare_outs(input string tag);
      check({tag, ".es_valid"}, 32'(es_valid), 32'(m_valid));
      check({tag, ".alu_op"}, 32'(alu_op), 32'(m_op));
      check({tag, ".src1"}, alu_src1, m_s1);
      check({tag, ".src2"}, alu_src2, m_s2);
      check({tag, ".es_ine"}, 32'(es_ine), 32'(m_ine));
   endtask

   // One clock: check handshake before the edge, advance the model, check outputs after.
   task automatic tick(input string tag);
      logic        go;
      logic [14:0] op;
      logic [31:0] s1, s2;
      logic        ine;
      #1;
      check({tag, ".ds_allowin"}, 32'(ds_allowin),
            32'(!m_valid || es_allowin || es_flush));
      @(posedge clk);
      go = ds_valid && !es_flush && (!m_valid || es_allowin);
      if (es_flush) m_valid = 1'b0;
      else if (go) m_valid = 1'b1;
      else if (es_allowin) m_valid = 1'b0;
      if (go) begin
         ref_dec(ds_inst, ds_pc, ds_rj_value, ds_rkd_value, op, s1, s2, ine);
         m_op = op;
         m_s1 = s1;
         m_s2 = s2;
         m_ine = ine;
      end
      #1;
      compare_outs(tag);
   endtask

   function automatic logic [31:0] rand_inst();
      int k;
      logic [31:0] low;
      if ($urandom_range(0, 4) == 0) return $urandom();
      k = int'($urandom_range(0, tbl.size() - 1));
      low = $urandom() & ((32'd1 << tbl[k].lo) - 32'd1);
      return (tbl[k].code << tbl[k].lo) | low;
   endfunction

   initial begin
      build_tbl();
      model_reset();
      #2;
      compare_outs("reset");
      check("reset.ds_allowin", 32'(ds_allowin), 32'd1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      set_in(1, 32'h00100C41, 32'h1C000000, 5, 7, 1, 0);
      tick("add_w");
      check("add_w.op_const", 32'(alu_op), 32'h0001);
      check("add_w.src1_const", alu_src1, 32'd5);
      check("add_w.src2_const", alu_src2, 32'd7);

      set_in(1, 32'h02BFFC41, 32'h1C000004, 3, 9, 1, 0);
      tick("addi_w");
      check("addi_w.src2_const", alu_src2, 32'hFFFFFFFF);
      set_in(1, 32'h03BFFC41, 32'h1C000008, 3, 9, 1, 0);
      tick("ori");
      check("ori.op_const", 32'(alu_op), 32'h0040);
      check("ori.src2_const", alu_src2, 32'h00000FFF);

      set_in(1, 32'h1C2468A1, 32'h1C000000, 77, 9, 1, 0);
      tick("pcaddu12i");
      check("pcaddu12i.src1_const", alu_src1, 32'h1C000000);
      check("pcaddu12i.src2_const", alu_src2, 32'h12345000);

      set_in(1, 32'h00110C41, 32'h1C000010, 11, 22, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick("stall");
         check("stall.ds_allowin_low", 32'(ds_allowin), 32'd0);
         check("stall.op_held", 32'(alu_op), 32'h0001);
      end
      es_allowin = 1'b1;
      tick("stall_release");
      check("stall_release.op_sub", 32'(alu_op), 32'h0002);

      set_in(1, 32'h00150C41, 32'h1C000014, 1, 2, 0, 1);
      tick("flush");
      check("flush.es_valid_const", 32'(es_valid), 32'd0);

      set_in(1, 32'h001C0C41, 32'h1C000018, 6, 7, 1, 0);
      tick("mul_w");
`ifdef ALU_ISSUE_MUL_EN
      check("mul_w.op_const", 32'(alu_op), 32'h1000);
      check("mul_w.ine_const", 32'(es_ine), 32'd0);
`else
      check("mul_w.op_const", 32'(alu_op), 32'h0000);
      check("mul_w.ine_const", 32'(es_ine), 32'd1);
`endif
      set_in(1, 32'hFFFFFFFF, 32'h1C00001C, 6, 7, 1, 0);
      tick("bad_inst");
      check("bad_inst.ine_const", 32'(es_ine), 32'd1);
      check("bad_inst.valid_const", 32'(es_valid), 32'd1);

      set_in(1, 32'h00100C41, 32'h1C000020, 4, 4, 0, 0);
      tick("pre_rst_stall");
      tick("pre_rst_stall");
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check("rst_mid.es_valid", 32'(es_valid), 32'd0);
      check("rst_mid.alu_op", 32'(alu_op), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      set_in(1, 32'h00128C41, 32'h1C000024, 8, 9, 0, 0);
      tick("post_rst");
      check("post_rst.valid_const", 32'(es_valid), 32'd1);

      for (int n = 0; n < 400; n++) begin
         set_in($urandom_range(0, 3) != 0, rand_inst(), $urandom(),
                $urandom(), $urandom(), $urandom_range(0, 2) != 0,
                $urandom_range(0, 9) == 0);
         tick("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
